// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter family.
//   CNT_WRAP / CNT_SAT : values for the SATURATE parameter
//   CNT_MAX_W          : widest supported counter
package counter_pkg;

    localparam int CNT_WRAP  = 0;
    localparam int CNT_SAT   = 1;
    localparam int CNT_MAX_W = 32;

endpackage

// File: rtl/updown_mod_next.sv
// Next-state logic of the up/down modulo counter (purely combinational).
// Ports:
//   i_count      current count
//   i_ld         load request (wins over inc/dec)
//   i_data_in    load value, clamped to MODULUS-1 when out of range
//   i_inc/i_dec  count up / count down (both or neither = hold)
//   o_count_nxt  next count
//   o_wrap_nxt   count wrapped, or a saturation end was hit
//   o_ld_err_nxt load value was clamped
module updown_mod_next
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 3,
    parameter longint MODULUS  = 8,
    parameter int     SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count_nxt,
    output logic             o_wrap_nxt,
    output logic             o_ld_err_nxt
);

    // All arithmetic is one bit wider than the count so that MODULUS-1 is
    // compared explicitly and 2**WIDTH rollover is never relied upon.
    localparam logic [WIDTH:0] LP_TOP = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] w_count_x;
    logic [WIDTH:0] w_data_x;
    logic [WIDTH:0] w_up_x;
    logic [WIDTH:0] w_down_x;

    assign w_count_x = {1'b0, i_count};
    assign w_data_x  = {1'b0, i_data_in};
    assign w_up_x    = w_count_x + (WIDTH+1)'(1);
    assign w_down_x  = w_count_x - (WIDTH+1)'(1);

    always_comb begin
        o_count_nxt  = i_count;
        o_wrap_nxt   = 1'b0;
        o_ld_err_nxt = 1'b0;
        if (i_ld) begin
            if (w_data_x > LP_TOP) begin
                o_count_nxt  = LP_TOP[WIDTH-1:0];
                o_ld_err_nxt = 1'b1;
            end else begin
                o_count_nxt = i_data_in;
            end
        end else if (i_inc && !i_dec) begin
            // Stepping past the top of the range.
            if (w_up_x > LP_TOP) begin
                o_wrap_nxt = 1'b1;
                if (SATURATE != CNT_SAT) begin
                    o_count_nxt = '0;
                end
            end else begin
                o_count_nxt = w_up_x[WIDTH-1:0];
            end
        end else if (i_dec && !i_inc) begin
            // Borrow out of the extended subtraction means the count was 0.
            if (w_down_x[WIDTH]) begin
                o_wrap_nxt = 1'b1;
                if (SATURATE != CNT_SAT) begin
                    o_count_nxt = LP_TOP[WIDTH-1:0];
                end
            end else begin
                o_count_nxt = w_down_x[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with wrap or saturate behaviour.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-low (loads RST_VAL)
//   clr       synchronous clear to RST_VAL (highest priority)
//   ld        synchronous load of data_in (clamped to MODULUS-1)
//   inc/dec   count up / count down by one
//   data_in   load value
//   data_out  registered count
//   wrap      registered pulse: wrapped or saturation end hit
//   ld_err    registered pulse: load value was clamped
//   at_max    data_out == MODULUS-1 (combinational)
//   at_min    data_out == 0 (combinational)
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 3,
    parameter longint MODULUS  = 8,
    parameter int     SATURATE = CNT_WRAP,
    parameter longint RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             wrap,
    output logic             ld_err,
    output logic             at_max,
    output logic             at_min
);

    if (WIDTH < 1 || WIDTH > CNT_MAX_W || MODULUS < 2 ||
        MODULUS > (longint'(1) << WIDTH) || RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_param_check
        $error("updown_mod_counter: WIDTH/MODULUS/RST_VAL out of range");
    end

    localparam logic [WIDTH:0]   LP_TOP = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LP_RST = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ld_err;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;
    logic             w_ld_err_nxt;

    updown_mod_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .i_count      (r_count),
        .i_ld         (ld),
        .i_data_in    (data_in),
        .i_inc        (inc),
        .i_dec        (dec),
        .o_count_nxt  (w_count_nxt),
        .o_wrap_nxt   (w_wrap_nxt),
        .o_ld_err_nxt (w_ld_err_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= LP_RST;
            r_wrap   <= 1'b0;
            r_ld_err <= 1'b0;
        end else if (clr) begin
            r_count  <= LP_RST;
            r_wrap   <= 1'b0;
            r_ld_err <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_wrap   <= w_wrap_nxt;
            r_ld_err <= w_ld_err_nxt;
        end
    end

    assign data_out = r_count;
    assign wrap     = r_wrap;
    assign ld_err   = r_ld_err;
    assign at_max   = ({1'b0, r_count} == LP_TOP);
    assign at_min   = (r_count == '0);

endmodule
